uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
UART receive front end. It oversamples the serial line, validates the start bit, shifts in data bits LSB first, and samples the stop bit. It presents the received byte, the stop-bit value and a one-cycle done strobe to the downstream RX error/status logic and the receive buffer. The downstream overrun/frame error logic consumes stop_bit directly, so stop_bit idles high.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate
rx_en  input  1  receiver enable; 0 forces IDLE at next clock
rx_in  input  1  raw serial line, asynchronous, idle high
rx_data  output  DATA_BITS  last received data word, held until next completed frame
rx_done  output  1  one-clk pulse when a frame completes, including frames with a bad stop bit
stop_bit  output  1  sampled stop-bit value of last frame, held
rx_busy  output  1  high in any state other than IDLE
parity_error  output  1  present only with UART_RX_PARITY_EN; held per frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: rx_data=0, rx_done=0, stop_bit=1, rx_busy=0, parity_error=0. FSM=IDLE, tick counter=0, bit counter=0, 2-FF synchronizer stages=1.
- Input synchronization: rx_in passes through a 2-FF synchronizer (rx_s). All decisions use rx_s.
- Tick counter: counts baud_tick, width clog2(OVERSAMPLE). It advances only on baud_tick and clears on every state change.
- IDLE:
  - On baud_tick with rx_s=0 and rx_en=1 -> START, counter=0.
- START:
  - At counter = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=1: false start -> IDLE, no outputs change.
  - rx_s=0: -> DATA, counter=0, bit count=0.
- DATA:
  - At counter = OVERSAMPLE-1, sample rx_s into shift_reg MSB and shift right (LSB first). bit count++.
  - After DATA_BITS samples -> PARITY (if enabled) else STOP.
- PARITY (macro only):
  - Sample at OVERSAMPLE-1. parity_bad = sample XOR (^shift_reg) XOR odd_sel. -> STOP.
- STOP:
  - At counter = OVERSAMPLE-1, sample rx_s.
  - Same clk: stop_bit <= sample, rx_data <= shift_reg, parity_error <= parity_bad, rx_done <= 1. -> IDLE.
- rx_done is high exactly one clk per completed frame. A frame takes 1+DATA_BITS(+1)+1 bit periods; rx_done rises half a bit before the nominal frame end.
- A stop bit of 0 still completes the frame, with stop_bit=0. The block does no resync wait; IDLE re-arms immediately. A line held at 0 therefore yields repeated frames, each with stop_bit=0.
- rx_en deasserted mid-frame: abort to IDLE on the next clk. rx_data and stop_bit keep their previous values; no rx_done.
- rst_n asserted mid-frame: all state and outputs return to reset values immediately.
- baud_tick coincident with a state change is consumed by the transition; it is not double-counted.

Optional Feature:
UART_RX_PARITY_EN:
- When defined: adds input odd_sel (1 = odd parity), the PARITY state, and the parity_error output. Frame length becomes 1+DATA_BITS+1+1 bits.
- When undefined: there is no parity state, no odd_sel or parity_error port, and the frame is 1+DATA_BITS+1 bits.

Test Plan:
- Frame 0xA5 with stop=1 at OVERSAMPLE=16 -> single rx_done pulse, rx_data=0xA5, stop_bit=1, rx_busy low after done.
- rx_in low for 4 ticks then high in IDLE -> returns to IDLE, no rx_done, rx_data unchanged.
- Frame 0x3C with stop=0 -> rx_done pulse, rx_data=0x3C, stop_bit=0; next good frame 0x00 restores stop_bit=1.
- Back-to-back frames 0x55, 0xFF with no idle gap -> two rx_done pulses, data in order; the second start bit is detected correctly.
- rst_n low during bit 4 of 0x81 -> outputs at reset values, FSM IDLE; the following 0x81 frame is received correctly. Repeat the abort case with rx_en=0 mid-frame -> no rx_done.
- With UART_RX_PARITY_EN, odd_sel=0: 0x07 with parity bit 1 -> parity_error=0; 0x07 with parity bit 0 -> parity_error=1, rx_done still pulses.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 2-FF input synchronizer, oversampled start/data/stop capture.
// Define UART_RX_PARITY_EN to add the parity bit, odd_sel input and parity_error output.
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 stop_bit,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                 odd_sel,
  output logic                 parity_error
`endif
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TW-1:0]  TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic [BCW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   rx_meta;
  logic                   rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad;

  function automatic logic calc_parity_bad(input logic sample,
                                           input logic [DATA_BITS-1:0] word,
                                           input logic odd);
    return sample ^ (^word) ^ odd;
  endfunction
`endif

  // Synchronizer stages idle high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      stop_bit     <= 1'b1;
      rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
      if (!rx_en) begin
        // Abort leaves the last frame's results untouched.
        state    <= IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        rx_busy  <= 1'b0;
      end else if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              rx_busy  <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == TICK_END) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_END) begin
              tick_cnt   <= '0;
              parity_bad <= calc_parity_bad(rx_s, shift_reg, odd_sel);
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          STOP: begin
            // A low stop bit still completes the frame; error logic downstream judges it.
            if (tick_cnt == TICK_END) begin
              tick_cnt     <= '0;
              stop_bit     <= rx_s;
              rx_data      <= shift_reg;
              rx_done      <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_error <= parity_bad;
`endif
              state        <= IDLE;
              rx_busy      <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            rx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n) rx_done |=> !rx_done);
  a_busy_match:  assert property (@(posedge clk) disable iff (!rst_n) rx_busy == (state != IDLE));

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: frames are queued as driven and
// compared when rx_done pulses.
module tb_uart_rx_deserializer;

  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam int TDIV = 4;
  localparam int BITCLK = OS * TDIV;

  logic          clk;
  logic          rst_n;
  logic          baud_tick;
  logic          rx_en;
  logic          rx_in;
  logic [DB-1:0] rx_data;
  logic          rx_done;
  logic          stop_bit;
  logic          rx_busy;
`ifdef UART_RX_PARITY_EN
  logic          odd_sel;
  logic          parity_error;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_exp   = 0;
  int div     = 0;
  logic [DB+1:0] sb[$];

  uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick    (baud_tick),
    .rx_en        (rx_en),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .stop_bit     (stop_bit),
    .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .odd_sel      (odd_sel),
    .parity_error (parity_error)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    div = (div == TDIV - 1) ? 0 : div + 1;
    baud_tick = (div == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [DB+1:0] e;
    if (rst_n && rx_done) begin
      n_done++;
      chk("sb_nonempty_at_done", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e[DB-1:0]));
        chk("stop_bit", 32'(stop_bit), 32'(e[DB]));
`ifdef UART_RX_PARITY_EN
        chk("parity_error", 32'(parity_error), 32'(e[DB+1]));
`endif
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop,
                            input logic par, input logic exp_perr);
    sb.push_back({exp_perr, stop, data});
    n_exp++;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  // Start bit plus nbits data bits, then half of the next bit; no frame expected.
  task automatic send_partial(input logic [DB-1:0] data, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    rx_in = data[nbits];
    repeat (BITCLK / 2) @(negedge clk);
  endtask

  initial begin
    int done_before;
    rst_n = 1'b0;
    rx_en = 1'b0;
    rx_in = 1'b1;
`ifdef UART_RX_PARITY_EN
    odd_sel = 1'b0;
`endif
    repeat (5) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rx_done", 32'(rx_done), 32'(0));
    chk("rst_stop_bit", 32'(stop_bit), 32'(1));
    chk("rst_rx_busy", 32'(rx_busy), 32'(0));
`ifdef UART_RX_PARITY_EN
    chk("rst_parity_error", 32'(parity_error), 32'(0));
`endif
    rst_n = 1'b1;
    rx_en = 1'b1;
    idle_bits(2);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    chk("busy_after_a5", 32'(rx_busy), 32'(0));
    chk("done_after_a5", 32'(n_done), 32'(1));

    done_before = n_done;
    rx_in = 1'b0;
    repeat (4 * TDIV) @(negedge clk);
    idle_bits(2);
    chk("false_start_no_done", 32'(n_done), 32'(done_before));
    chk("false_start_data", 32'(rx_data), 32'(8'hA5));
    chk("false_start_busy", 32'(rx_busy), 32'(0));

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle_bits(2);
    chk("held_stop_low", 32'(stop_bit), 32'(0));
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    chk("stop_restored", 32'(stop_bit), 32'(1));

    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle_bits(2);
    chk("b2b_done_count", 32'(n_done), 32'(n_exp));

    send_partial(8'h81, 4);
    chk("busy_mid_frame", 32'(rx_busy), 32'(1));
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    chk("mid_rst_rx_data", 32'(rx_data), 32'(0));
    chk("mid_rst_stop_bit", 32'(stop_bit), 32'(1));
    chk("mid_rst_rx_busy", 32'(rx_busy), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle_bits(1);

    done_before = n_done;
    send_partial(8'h81, 4);
    rx_en = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy", 32'(rx_busy), 32'(0));
    rx_en = 1'b1;
    idle_bits(12);
    chk("abort_no_done", 32'(n_done), 32'(done_before));
    chk("abort_data_kept", 32'(rx_data), 32'(8'h81));
    chk("abort_stop_kept", 32'(stop_bit), 32'(1));
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle_bits(1);

`ifdef UART_RX_PARITY_EN
    odd_sel = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle_bits(1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    odd_sel = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
`endif

    chk("sb_empty", 32'(sb.size()), 32'(0));
    chk("done_count", 32'(n_done), 32'(n_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
